// File: rtl/chip8_memory.sv
// ----------------------------------------------------------------------------
// chip8_memory
//
// 4 KB CHIP-8 main memory. This block answers the CPU fetch interface: the
// CPU's 12-bit address comes in on in_address, and the addressed byte returns
// on out_data one cycle later. The block also takes CPU data writes and
// program bytes from a byte-stream loader.
//
// After reset, an internal FSM copies the 80-byte hex font into RAM starting
// at FONT_BASE, one byte per cycle. Once the copy is done, the FSM enters
// READY, and from then on the memory serves reads, loader bytes and CPU writes.
// Reset clears the FSM and the registers. It does not clear the RAM contents.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   in_address    CPU read address (12 bit)
//   out_data      registered read data (8 bit), 8'h00 until READY
//   wr_en         CPU write strobe
//   wr_address    CPU write address (12 bit)
//   wr_data       CPU write data (8 bit)
//   load_en       loader byte valid
//   load_data     loader byte (8 bit)
//   load_clear    rewind load pointer to PROGRAM_BASE, clear load_overflow
//   ready         font copy complete; memory serving normally
//   load_count    bytes accepted since the last rewind (12 bit)
//   load_overflow sticky flag: a loader byte was dropped past 12'hFFF
// ----------------------------------------------------------------------------
module chip8_memory #(
  parameter logic [11:0] FONT_BASE    = 12'h050,
  parameter logic [11:0] PROGRAM_BASE = 12'h200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] in_address,
  output logic [7:0]  out_data,
  input  logic        wr_en,
  input  logic [11:0] wr_address,
  input  logic [7:0]  wr_data,
  input  logic        load_en,
  input  logic [7:0]  load_data,
  input  logic        load_clear,
  output logic        ready,
  output logic [11:0] load_count,
  output logic        load_overflow
);

  // Standard CHIP-8 hex font. Glyph 0 byte 0 sits in the most significant byte.
  localparam logic [639:0] FONT_ROM = {
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
  };

  localparam logic [6:0] FONT_LAST = 7'd79;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [6:0]  font_idx_reg, font_idx_next;

  logic [11:0] load_ptr_reg;
  logic        load_exhausted_reg;   // the byte at 12'hFFF has been written
  logic [11:0] load_count_reg;
  logic        load_overflow_reg;

  logic        rd_valid_reg;         // the read register holds a READY-state read
  logic [7:0]  rd_data_reg;

  logic [7:0]  font_byte;
  logic        load_accept;
  logic        mem_we;
  logic [11:0] mem_waddr;
  logic [7:0]  mem_wdata;

  logic [7:0]  mem [0:4095];

  // idx*8 selects the byte, counted from the top of the ROM vector.
  assign font_byte = FONT_ROM[10'd639 - {font_idx_reg, 3'b000} -: 8];

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= INIT;
      font_idx_reg <= 7'd0;
    end else begin
      state_reg    <= state_next;
      font_idx_reg <= font_idx_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and the single RAM write port.
  // INIT owns the write port for the font copy.
  // In READY, an accepted loader byte beats a CPU write in the same cycle.
  // A dropped loader byte (exhausted or cleared) does not block the CPU.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    font_idx_next = font_idx_reg;
    load_accept   = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = 12'h000;
    mem_wdata     = 8'h00;

    case (state_reg)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = FONT_BASE + {5'b00000, font_idx_reg};
        mem_wdata = font_byte;
        if (font_idx_reg == FONT_LAST) begin
          state_next    = READY;
          font_idx_next = 7'd0;
        end else begin
          font_idx_next = font_idx_reg + 7'd1;
        end
      end

      READY: begin
        load_accept = load_en && !load_clear && !load_exhausted_reg;
        if (load_accept) begin
          mem_we    = 1'b1;
          mem_waddr = load_ptr_reg;
          mem_wdata = load_data;
        end else if (wr_en) begin
          mem_we    = 1'b1;
          mem_waddr = wr_address;
          mem_wdata = wr_data;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Loader pointer, count and overflow flag.
  // The pointer stops at 12'hFFF. After that byte is written, the exhausted
  // flag marks the end of the load, so the pointer never wraps to 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_ptr_reg       <= PROGRAM_BASE;
      load_exhausted_reg <= 1'b0;
      load_count_reg     <= 12'h000;
      load_overflow_reg  <= 1'b0;
    end else if (state_reg == READY) begin
      if (load_clear) begin
        load_ptr_reg       <= PROGRAM_BASE;
        load_exhausted_reg <= 1'b0;
        load_count_reg     <= 12'h000;
        load_overflow_reg  <= 1'b0;
      end else if (load_en) begin
        if (load_exhausted_reg) begin
          load_overflow_reg <= 1'b1;
        end else begin
          load_count_reg <= load_count_reg + 12'd1;
          if (load_ptr_reg == 12'hFFF) begin
            load_exhausted_reg <= 1'b1;
          end else begin
            load_ptr_reg <= load_ptr_reg + 12'd1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM array with a registered read.
  // The read and write ports are not reset, so the array maps to block RAM.
  // A read and a write to the same address in the same cycle return the old
  // byte.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data_reg <= mem[in_address];
  end

  // Masks out_data to zero until reads are issued from READY. This keeps the
  // reset value off the RAM output register itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= (state_reg == READY);
    end
  end

  assign out_data      = rd_valid_reg ? rd_data_reg : 8'h00;
  assign ready         = (state_reg == READY);
  assign load_count    = load_count_reg;
  assign load_overflow = load_overflow_reg;

endmodule

// File: tb/tb_chip8_memory.sv
// ----------------------------------------------------------------------------
// tb_chip8_memory
//
// Directed self-checking bench for chip8_memory. Each task drives one
// scenario and checks its results inline.
// ----------------------------------------------------------------------------
module tb_chip8_memory;

  logic        clk;
  logic        reset;
  logic [11:0] in_address;
  logic [7:0]  out_data;
  logic        wr_en;
  logic [11:0] wr_address;
  logic [7:0]  wr_data;
  logic        load_en;
  logic [7:0]  load_data;
  logic        load_clear;
  logic        ready;
  logic [11:0] load_count;
  logic        load_overflow;

  int n_cmp;
  int n_err;

  localparam logic [7:0] FONT [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  chip8_memory dut (
    .clk           (clk),
    .reset         (reset),
    .in_address    (in_address),
    .out_data      (out_data),
    .wr_en         (wr_en),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .load_en       (load_en),
    .load_data     (load_data),
    .load_clear    (load_clear),
    .ready         (ready),
    .load_count    (load_count),
    .load_overflow (load_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge. Inputs are driven and outputs sampled 1 ns
  // after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an address, wait one edge, then check the byte returned.
  task automatic read_check(input string name, input logic [11:0] addr, input logic [7:0] exp);
    in_address = addr;
    tick();
    n_cmp++;
    if (out_data !== exp) begin
      n_err++;
      $display("FAIL %s addr=%03h out_data=%02h expected=%02h", name, addr, out_data, exp);
    end else begin
      $display("ok   %s addr=%03h out_data=%02h", name, addr, out_data);
    end
  endtask

  // With reset just released, check ready stays low through edge 79 and
  // rises at edge 80.
  task automatic check_ready_timing(input string name);
    repeat (79) tick();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_early ready=%0b expected=0 after 79 edges", name, ready);
    end
    // Stop any INIT-time stimulus before the first READY edge.
    wr_en = 1'b0; load_en = 1'b0; load_clear = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_rise ready=%0b expected=1 after 80 edges", name, ready);
    end else begin
      $display("ok   %s ready rose after 80 edges", name);
    end
  endtask

  // Read all 80 font bytes back and count the ones that do not match.
  task automatic check_full_font(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      in_address = 12'h050 + 12'(i);
      tick();
      if (out_data !== FONT[i]) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s bad_bytes=%0d expected=0", name, bad);
    end else begin
      $display("ok   %s all 80 font bytes", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({ready, out_data, load_count, load_overflow} !== 22'h0) begin
      n_err++;
      $display("FAIL reset_state ready=%0b out=%02h cnt=%03h ovf=%0b expected all 0",
               ready, out_data, load_count, load_overflow);
    end else begin
      $display("ok   reset_state");
    end
    reset = 1'b1;
    check_ready_timing("boot");
    read_check("font_050", 12'h050, 8'hF0);
    read_check("font_051", 12'h051, 8'h90);
    read_check("font_055", 12'h055, 8'h20);
    read_check("font_09F", 12'h09F, 8'h80);
  endtask

  // Writes to 0x123 and 0x400 in READY set known values for later checks.
  task automatic test_cpu_write();
    wr_en = 1'b1; wr_address = 12'h123; wr_data = 8'h5A;
    tick();
    wr_address = 12'h400; wr_data = 8'h00;
    tick();
    wr_en = 1'b0;
    read_check("cpu_write_123", 12'h123, 8'h5A);
  endtask

  // Reset again, interrupt INIT at cycle 40, then push writes, loads and
  // clears through the restarted INIT. None of them may take effect.
  task automatic test_reset_mid_init();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (40) tick();
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (ready !== 1'b0 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL mid_init_reset ready=%0b out=%02h expected 0/00", ready, out_data);
    end
    reset = 1'b1;
    wr_en = 1'b1; wr_address = 12'h123; wr_data = 8'h99;
    load_en = 1'b1; load_data = 8'h77;
    check_ready_timing("restart");
    n_cmp++;
    if (load_count !== 12'h000) begin
      n_err++;
      $display("FAIL init_load_ignored load_count=%03h expected=000", load_count);
    end
    read_check("init_write_ignored", 12'h123, 8'h5A);
    check_full_font("font_after_restart");
  endtask

  task automatic test_load_basic();
    load_en = 1'b1;
    load_data = 8'h12; tick();
    load_data = 8'h34; tick();
    load_data = 8'h56; tick();
    load_en = 1'b0;
    n_cmp++;
    if (load_count !== 12'd3 || load_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL load3_count cnt=%03h ovf=%0b expected=003/0", load_count, load_overflow);
    end
    read_check("load_200", 12'h200, 8'h12);
    read_check("load_201", 12'h201, 8'h34);
    read_check("load_202", 12'h202, 8'h56);
  endtask

  // Rewind, fill 0x200..0x2FF, then collide a CPU write and a loader byte
  // on 0x300.
  task automatic test_write_priority();
    load_clear = 1'b1; tick(); load_clear = 1'b0;
    load_en = 1'b1; load_data = 8'h00;
    repeat (256) tick();
    load_data = 8'h22;
    wr_en = 1'b1; wr_address = 12'h300; wr_data = 8'h11;
    tick();
    load_en = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (load_count !== 12'h101) begin
      n_err++;
      $display("FAIL prio_count load_count=%03h expected=101", load_count);
    end
    read_check("prio_loader_wins", 12'h300, 8'h22);
  endtask

  task automatic test_overflow();
    load_clear = 1'b1; tick(); load_clear = 1'b0;
    load_en = 1'b1; load_data = 8'hA5;
    repeat (3584) tick();
    load_en = 1'b0;
    n_cmp++;
    if (load_count !== 12'hE00 || load_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fill_exact cnt=%03h ovf=%0b expected=E00/0", load_count, load_overflow);
    end
    // One extra byte with a different value must not land anywhere.
    load_en = 1'b1; load_data = 8'h3C; tick(); load_en = 1'b0;
    n_cmp++;
    if (load_count !== 12'hE00 || load_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow cnt=%03h ovf=%0b expected=E00/1", load_count, load_overflow);
    end else begin
      $display("ok   overflow cnt=%03h ovf=%0b", load_count, load_overflow);
    end
    read_check("ovf_mem_FFF", 12'hFFF, 8'hA5);
    read_check("ovf_mem_200", 12'h200, 8'hA5);
    read_check("ovf_font_intact", 12'h09F, 8'h80);
    // load_clear beats load_en in the same cycle, and the byte is dropped.
    load_clear = 1'b1; load_en = 1'b1; load_data = 8'hEE; tick();
    load_clear = 1'b0; load_en = 1'b0;
    n_cmp++;
    if (load_count !== 12'h000 || load_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear cnt=%03h ovf=%0b expected=000/0", load_count, load_overflow);
    end
    read_check("clear_dropped_byte", 12'h200, 8'hA5);
    load_en = 1'b1; load_data = 8'h42; tick(); load_en = 1'b0;
    n_cmp++;
    if (load_count !== 12'd1) begin
      n_err++;
      $display("FAIL rewind_count load_count=%03h expected=001", load_count);
    end
    read_check("rewind_200", 12'h200, 8'h42);
  endtask

  task automatic test_read_during_write();
    // The overflow stream covered 0x400, so restore the old value first.
    wr_en = 1'b1; wr_address = 12'h400; wr_data = 8'h00; tick();
    in_address = 12'h400; wr_data = 8'h7E;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if (out_data !== 8'h00) begin
      n_err++;
      $display("FAIL rdw_old out_data=%02h expected=00", out_data);
    end else begin
      $display("ok   rdw_old out_data=%02h", out_data);
    end
    tick();
    n_cmp++;
    if (out_data !== 8'h7E) begin
      n_err++;
      $display("FAIL rdw_new out_data=%02h expected=7E", out_data);
    end else begin
      $display("ok   rdw_new out_data=%02h", out_data);
    end
    // The font region has no write protection.
    wr_en = 1'b1; wr_address = 12'h050; wr_data = 8'h3B; tick(); wr_en = 1'b0;
    read_check("font_overwrite", 12'h050, 8'h3B);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0;
    in_address = 12'h000;
    wr_en = 1'b0; wr_address = 12'h000; wr_data = 8'h00;
    load_en = 1'b0; load_data = 8'h00; load_clear = 1'b0;

    test_reset();
    test_cpu_write();
    test_reset_mid_init();
    test_load_basic();
    test_write_priority();
    test_overflow();
    test_read_during_write();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chip8_memory.md
Name: chip8_memory

Overview:
4 KB CHIP-8 main memory. It is the responder side of the CPU fetch interface: it takes the CPU's 12-bit out_address and returns the byte on the CPU's in_data.
- After reset, an internal FSM copies the 80-byte hex font into RAM at FONT_BASE.
- A byte-stream loader then writes the program image from PROGRAM_BASE upward.
- The block also accepts CPU data writes (FX33/FX55).

Parameters:
FONT_BASE, 12'h050, address of font glyph "0" byte 0; glyphs 0..F are contiguous, 5 bytes each.
PROGRAM_BASE, 12'h200, first address written by the loader after reset or load_clear.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
in_address  input  12  CPU read address (driven from CPU out_address)
out_data  output  8  read data to CPU in_data, registered
wr_en  input  1  CPU write strobe
wr_address  input  12  CPU write address
wr_data  input  8  CPU write data
load_en  input  1  loader byte valid
load_data  input  8  loader byte
load_clear  input  1  pulse: rewind load pointer to PROGRAM_BASE, clear load_overflow
ready  output  1  font copy complete; memory serving normally
load_count  output  12  bytes accepted since last rewind
load_overflow  output  1  sticky: a load byte was dropped past 12'hFFF

Behaviour:
- Storage is 4096 x 8 synchronous RAM. Memory contents are not cleared by reset; only FSM and registers are.
- Reset values (reset=0):
  - state=INIT, font index=0
  - ready=0, out_data=8'h00
  - load pointer=PROGRAM_BASE, load_count=0, load_overflow=0
- FSM state INIT:
  - Each cycle writes font[idx] to FONT_BASE+idx, then idx++. idx runs 0..79.
  - Font ROM is combinational, standard CHIP-8 set: 0 = F0 90 90 90 F0, 1 = 20 60 20 20 70, ..., F = F0 80 F0 80 80.
  - The first font write occurs on the first rising clk edge with reset=1.
  - After the idx=79 write, the FSM moves to READY. ready=1 from the following edge, i.e. 80 cycles after reset release.
- In INIT, CPU writes, loader bytes and load_clear are ignored (not queued), and out_data holds 8'h00.
- Reset asserted mid-INIT or mid-load returns to INIT immediately; the font copy restarts from idx=0.
- FSM state READY:
  - Read: out_data <= mem[in_address] every cycle, 1-cycle latency.
  - Read-during-write to the same address returns the old byte; the new byte is visible the next cycle.
  - Loader: when load_en=1, write load_data at the load pointer, then increment the pointer and load_count.
  - Load pointer at 12'hFFF: that byte is written and the pointer saturates in an "exhausted" condition. Further load_en bytes are dropped and set load_overflow=1. load_count saturates at 12'hE00 (3584) for PROGRAM_BASE=0x200.
  - CPU write: when wr_en=1, mem[wr_address] <= wr_data.
  - wr_en and load_en in the same cycle: the loader write wins and the CPU write is dropped.
  - load_clear has priority over load_en in the same cycle: the byte is dropped and the pointer is rewound.
  - Writes are permitted to any address, including the font region; there is no protection.
- READY is left only by reset.
- Addresses are exactly 12 bits, and no address arithmetic wraps except the font index. The load pointer saturates; it never wraps to 0x000.

Test Plan:
- Reset low 3 cycles then high -> ready=0 for cycles 1..80, ready=1 at cycle 81. Reads return: 0x050 -> F0, 0x051 -> 90, 0x055 -> 20, 0x09F -> 80.
- Reset asserted at INIT cycle 40 for 2 cycles, then released -> ready again exactly 80 cycles after release. Full font is intact.
- Load bytes 12,34,56 on consecutive cycles -> load_count=3. Read 0x200/0x201/0x202 -> 12/34/56 one cycle after address presented. load_overflow=0.
- Stream 3585 bytes (pattern A5) -> load_count=3584, load_overflow=1, mem[0xFFF]=A5, mem[0x200] unchanged by the extra byte. Then load_clear -> load_count=0, load_overflow=0.
- Same cycle wr_en (0x300<-0x11) and load_en (pointer 0x300, data 0x22) -> mem[0x300]=22.
- Same-cycle write and read of 0x400 (old 00, write 7E) -> out_data=00 next cycle, 7E the cycle after. wr_en during INIT -> address unchanged after ready.
